cache_line_sequencer: RTL and testbench

CACHE_LINE_SEQUENCER -- requirements
Module: cache_line_sequencer

---
 rtl/cache_line_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cache_line_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_sequencer.sv
// cache_line_sequencer: moves one cache line between the data RAM and the
// memory bus, one 32-bit word at a time. A fill reads words from the bus and
// writes them into the RAM. A writeback reads words from the RAM and writes
// them to the bus.
module cache_line_sequencer #(
  parameter int nr_entries  = 32,
  parameter int line_words  = 8,
  localparam int addr_bits  = $clog2(nr_entries),
  localparam int offs_bits  = $clog2(line_words),
  localparam int index_bits = addr_bits - offs_bits
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic                  wb_req,
  input  logic [index_bits-1:0] line_index,
  input  logic [31:0]           line_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_data,
  output logic                  m_access,
  output logic                  m_wr_en,
  output logic [3:0]            m_bytesel,
  input  logic                  m_ack,
  input  logic [31:0]           m_data_in,
  output logic [addr_bits-1:0]  ram_read_addr,
  input  logic [31:0]           ram_read_data,
  output logic                  ram_wr_en,
  output logic [addr_bits-1:0]  ram_write_addr,
  output logic [31:0]           ram_write_data,
  output logic [3:0]            ram_bytesel
);

  typedef enum logic [2:0] {
    IDLE, FILL, FILL_GAP, WB_RD, WB_WR, DONE
  } state_t;

  localparam logic [offs_bits-1:0] W_LAST = offs_bits'(line_words - 1);

  state_t                  state_q;
  logic [offs_bits-1:0]    w_q;
  logic [index_bits-1:0]   idx_q;
  logic [29-offs_bits:0]   base_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    acc_q;
  logic                    wren_q;
  logic                    first_q;
  logic [31:0]             mdata_q;
  logic [addr_bits-1:0]    rd_addr_q;

  logic                    ack;
  logic                    last;
  logic [offs_bits-1:0]    w_inc;

  // Byte offset and word offset of line_addr are replaced by the word counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^line_addr[1+offs_bits:0];

  // An acknowledge only counts while a bus access is actually outstanding.
  assign ack   = acc_q & m_ack;
  assign last  = (w_q == W_LAST);
  assign w_inc = w_q + 1'b1;

  // Sequencer FSM: request capture, word counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= 1'b0;
      wren_q    <= 1'b0;
      first_q   <= 1'b0;
      mdata_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb_req || fill_req) begin
            idx_q     <= line_index;
            base_q    <= line_addr[31:2+offs_bits];
            w_q       <= '0;
            busy_q    <= 1'b1;
            rd_addr_q <= {line_index, {offs_bits{1'b0}}};
            // Writeback wins so a dirty line is saved before being replaced.
            if (wb_req) begin
              state_q <= WB_RD;
            end else begin
              state_q <= FILL;
              acc_q   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (ack) begin
            acc_q <= 1'b0;
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              w_q     <= w_inc;
              state_q <= FILL_GAP;
            end
          end
        end
        FILL_GAP: begin
          acc_q   <= 1'b1;
          state_q <= FILL;
        end
        WB_RD: begin
          acc_q   <= 1'b1;
          wren_q  <= 1'b1;
          first_q <= 1'b1;
          state_q <= WB_WR;
        end
        WB_WR: begin
          first_q <= 1'b0;
          if (first_q) mdata_q <= ram_read_data;
          if (ack) begin
            acc_q  <= 1'b0;
            wren_q <= 1'b0;
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              w_q       <= w_inc;
              rd_addr_q <= {idx_q, w_inc};
              state_q   <= WB_RD;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_access  = acc_q;
  assign m_wr_en   = wren_q;
  assign m_bytesel = acc_q ? 4'b1111 : 4'b0000;
  assign m_addr    = {base_q, w_q, 2'b00};
  // The RAM word only arrives in the first WB_WR cycle, so it is forwarded
  // straight to the bus then and held from the capture register afterwards.
  assign m_data    = first_q ? ram_read_data : mdata_q;

  assign ram_read_addr  = rd_addr_q;
  // RAM writes follow the fill ack directly; reset kills a write in flight.
  assign ram_wr_en      = (state_q == FILL) & ack & ~rst;
  assign ram_write_addr = {idx_q, w_q};
  assign ram_write_data = m_data_in;
  assign ram_bytesel    = ram_wr_en ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Directed bench for cache_line_sequencer with line_words=4, nr_entries=32.
// Includes a registered-read RAM model and a bus slave with programmable
// ack latency.
module tb_cache_line_sequencer;
  localparam int NR = 32;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst, fill_req, wb_req;
  logic [2:0]  line_index;
  logic [31:0] line_addr;
  logic        busy, done, m_access, m_wr_en, m_ack, ram_wr_en;
  logic [31:0] m_addr, m_data, m_data_in, ram_rdata, ram_write_data;
  logic [3:0]  m_bytesel, ram_bytesel;
  logic [4:0]  ram_read_addr, ram_write_addr;

  cache_line_sequencer #(.nr_entries(NR), .line_words(LW)) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .wb_req(wb_req),
    .line_index(line_index), .line_addr(line_addr),
    .busy(busy), .done(done), .m_addr(m_addr), .m_data(m_data),
    .m_access(m_access), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .m_ack(m_ack), .m_data_in(m_data_in),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_rdata),
    .ram_wr_en(ram_wr_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_bytesel(ram_bytesel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // RAM model with preload port
  logic [31:0] mem [0:NR-1];
  logic [31:0] ram_mask;
  logic        pre_en = 1'b0;
  logic [4:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  int          wr_cnt = 0;
  assign ram_mask = {{8{ram_bytesel[3]}}, {8{ram_bytesel[2]}},
                     {8{ram_bytesel[1]}}, {8{ram_bytesel[0]}}};
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    if (ram_wr_en) begin
      mem[ram_write_addr] <= (mem[ram_write_addr] & ~ram_mask) | (ram_write_data & ram_mask);
      wr_cnt <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_read_addr];
  end

  // Bus slave: acks after ack_delay waiting cycles, read data derived from address
  int acc_cnt = 0;
  int ack_delay = 0;
  assign m_ack     = m_access && (acc_cnt >= ack_delay);
  assign m_data_in = m_addr ^ 32'hF000_0000;
  always @(posedge clk) begin
    if (!m_access || m_ack) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  logic [31:0] wb_pat [0:3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};

  // Per-cycle capture, index = cycles after the request cycle
  logic        cap_acc [0:31], cap_wr [0:31], cap_we [0:31], cap_done [0:31], cap_busy [0:31];
  logic [31:0] cap_addr [0:31], cap_mdata [0:31], cap_wd [0:31];
  logic [4:0]  cap_wa [0:31];
  logic [3:0]  cap_bsel [0:31], cap_rbsel [0:31];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic preset(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = 5'(a); pre_d = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic issue(input bit f, input bit w, input logic [2:0] idx, input logic [31:0] a);
    @(negedge clk);
    fill_req = f; wb_req = w; line_index = idx; line_addr = a;
  endtask

  task automatic capture(input int ncyc, input bit keep_fill);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      wb_req = 1'b0;
      if (!keep_fill) fill_req = 1'b0;
      cap_acc[c] = m_access;  cap_wr[c] = m_wr_en;   cap_we[c] = ram_wr_en;
      cap_done[c] = done;     cap_busy[c] = busy;    cap_addr[c] = m_addr;
      cap_mdata[c] = m_data;  cap_wd[c] = ram_write_data; cap_wa[c] = ram_write_addr;
      cap_bsel[c] = m_bytesel; cap_rbsel[c] = ram_bytesel;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fill_req = 1'b0; wb_req = 1'b0; line_index = '0; line_addr = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, m_access, m_wr_en, ram_wr_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b exp 00000", {busy, done, m_access, m_wr_en, ram_wr_en});
    end
    n_cmp++;
    if (m_addr !== 32'h0 || m_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got addr %h data %h exp 0", m_addr, m_data);
    end
    n_cmp++;
    if (m_bytesel !== 4'h0 || ram_bytesel !== 4'h0) begin
      n_fail++; $display("FAIL reset_bsel got %h/%h exp 0/0", m_bytesel, ram_bytesel);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill(input int d, input logic [2:0] idx, input logic [31:0] a);
    int p, k, ph, w0, nc;
    logic e_acc, e_we;
    logic [31:0] base, e_addr;
    p = d + 2; base = a & ~32'hF; nc = 4 * p + 1;
    ack_delay = d;
    w0 = wr_cnt;
    issue(1'b1, 1'b0, idx, a);
    capture(nc, 1'b0);
    for (int c = 1; c <= nc; c++) begin
      k = (c - 1) / p; ph = (c - 1) % p;
      e_acc = (k < 4) && (ph <= d);
      e_we  = e_acc && (ph == d);
      e_addr = base + 32'(4 * k);
      n_cmp++;
      if (cap_acc[c] !== e_acc) begin
        n_fail++; $display("FAIL fill_acc d=%0d c=%0d got %b exp %b", d, c, cap_acc[c], e_acc);
      end
      n_cmp++;
      if (cap_we[c] !== e_we) begin
        n_fail++; $display("FAIL fill_ramwe d=%0d c=%0d got %b exp %b", d, c, cap_we[c], e_we);
      end
      n_cmp++;
      if (cap_rbsel[c] !== (e_we ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL fill_rbsel d=%0d c=%0d got %h", d, c, cap_rbsel[c]);
      end
      if (e_acc) begin
        n_cmp++;
        if (cap_addr[c] !== e_addr || cap_wr[c] !== 1'b0 || cap_bsel[c] !== 4'hF) begin
          n_fail++; $display("FAIL fill_bus d=%0d c=%0d got %h/%b/%h exp %h/0/f",
                             d, c, cap_addr[c], cap_wr[c], cap_bsel[c], e_addr);
        end
      end else begin
        n_cmp++;
        if (cap_bsel[c] !== 4'h0) begin
          n_fail++; $display("FAIL fill_bsel_idle d=%0d c=%0d got %h exp 0", d, c, cap_bsel[c]);
        end
      end
      if (e_we) begin
        n_cmp++;
        if (cap_wa[c] !== 5'(idx * 4 + k) || cap_wd[c] !== (e_addr ^ 32'hF000_0000)) begin
          n_fail++; $display("FAIL fill_ramwr d=%0d c=%0d got %0d/%h exp %0d/%h",
                             d, c, cap_wa[c], cap_wd[c], idx * 4 + k, e_addr ^ 32'hF000_0000);
        end
      end
      n_cmp++;
      if (cap_done[c] !== (c == 4 * p) || cap_busy[c] !== (c < 4 * p)) begin
        n_fail++; $display("FAIL fill_status d=%0d c=%0d got done %b busy %b", d, c, cap_done[c], cap_busy[c]);
      end
    end
    n_cmp++;
    if (wr_cnt - w0 != 4) begin
      n_fail++; $display("FAIL fill_wrcount got %0d exp 4", wr_cnt - w0);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (mem[idx * 4 + j] !== ((base + 32'(4 * j)) ^ 32'hF000_0000)) begin
        n_fail++; $display("FAIL fill_mem w=%0d got %h exp %h", j, mem[idx * 4 + j],
                           (base + 32'(4 * j)) ^ 32'hF000_0000);
      end
    end
  endtask

  task automatic test_writeback(input int d, input logic [2:0] idx, input logic [31:0] a);
    int p, k, ph, w0, nc;
    logic e_acc;
    logic [31:0] e_addr;
    p = d + 2; nc = 4 * p + 2;
    for (int j = 0; j < 4; j++) preset(idx * 4 + j, wb_pat[j]);
    ack_delay = d;
    w0 = wr_cnt;
    issue(1'b0, 1'b1, idx, a);
    capture(nc, 1'b0);
    for (int c = 1; c <= nc; c++) begin
      k = (c - 1) / p; ph = (c - 1) % p;
      e_acc = (k < 4) && (ph >= 1);
      e_addr = (a & ~32'hF) + 32'(4 * k);
      n_cmp++;
      if (cap_acc[c] !== e_acc || cap_we[c] !== 1'b0) begin
        n_fail++; $display("FAIL wb_acc d=%0d c=%0d got acc %b ramwe %b exp %b/0", d, c, cap_acc[c], cap_we[c], e_acc);
      end
      if (e_acc) begin
        n_cmp++;
        if (cap_addr[c] !== e_addr || cap_wr[c] !== 1'b1 || cap_bsel[c] !== 4'hF) begin
          n_fail++; $display("FAIL wb_bus d=%0d c=%0d got %h/%b/%h exp %h/1/f",
                             d, c, cap_addr[c], cap_wr[c], cap_bsel[c], e_addr);
        end
        n_cmp++;
        if (cap_mdata[c] !== wb_pat[k]) begin
          n_fail++; $display("FAIL wb_data d=%0d c=%0d got %h exp %h", d, c, cap_mdata[c], wb_pat[k]);
        end
      end
      n_cmp++;
      if (cap_done[c] !== (c == 4 * p + 1) || cap_busy[c] !== (c <= 4 * p)) begin
        n_fail++; $display("FAIL wb_status d=%0d c=%0d got done %b busy %b", d, c, cap_done[c], cap_busy[c]);
      end
    end
    n_cmp++;
    if (wr_cnt != w0) begin
      n_fail++; $display("FAIL wb_ramwrites got %0d exp 0", wr_cnt - w0);
    end
  endtask

  task automatic test_priority();
    bit seen;
    for (int j = 0; j < 4; j++) preset(4 + j, wb_pat[j]);
    ack_delay = 0;
    issue(1'b1, 1'b1, 3'd1, 32'h2000);
    capture(12, 1'b1);
    fill_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_cmp++;
      if (cap_acc[c] !== (c % 2 == 0) || cap_we[c] !== 1'b0) begin
        n_fail++; $display("FAIL prio_acc c=%0d got acc %b ramwe %b", c, cap_acc[c], cap_we[c]);
      end
      if (c % 2 == 0) begin
        n_cmp++;
        if (cap_wr[c] !== 1'b1 || cap_mdata[c] !== wb_pat[(c - 2) / 2]) begin
          n_fail++; $display("FAIL prio_wb c=%0d got wr %b data %h exp 1/%h", c, cap_wr[c], cap_mdata[c], wb_pat[(c - 2) / 2]);
        end
      end
    end
    n_cmp++;
    if (cap_done[9] !== 1'b1 || cap_busy[10] !== 1'b0 || cap_acc[10] !== 1'b0) begin
      n_fail++; $display("FAIL prio_done got done9 %b busy10 %b acc10 %b exp 1/0/0", cap_done[9], cap_busy[10], cap_acc[10]);
    end
    n_cmp++;
    if (cap_acc[11] !== 1'b1 || cap_wr[11] !== 1'b0 || cap_addr[11] !== 32'h2000 ||
        cap_we[11] !== 1'b1 || cap_wa[11] !== 5'd4) begin
      n_fail++; $display("FAIL prio_fill got acc %b wr %b addr %h we %b wa %0d exp 1/0/2000/1/4",
                         cap_acc[11], cap_wr[11], cap_addr[11], cap_we[11], cap_wa[11]);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL prio_fill_done got timeout exp done within 20 cycles");
    end
  endtask

  task automatic test_ack_delay();
    test_fill(3, 3'd3, 32'h0000_300E);
    test_writeback(3, 3'd1, 32'h0000_2000);
  endtask

  task automatic test_reset_abort();
    int w0;
    bit bad;
    for (int j = 0; j < 4; j++) preset(20 + j, 32'hDEAD_BEEF);
    ack_delay = 0;
    w0 = wr_cnt;
    issue(1'b1, 1'b0, 3'd5, 32'h5000);
    @(negedge clk); fill_req = 1'b0;
    n_cmp++;
    if (m_access !== 1'b1 || m_addr !== 32'h5000) begin
      n_fail++; $display("FAIL abort_w0 got acc %b addr %h exp 1/5000", m_access, m_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_access !== 1'b1 || m_addr !== 32'h5004) begin
      n_fail++; $display("FAIL abort_w1 got acc %b addr %h exp 1/5004", m_access, m_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, m_access, m_wr_en, ram_wr_en} !== 5'b0 || m_addr !== 32'h0 ||
        m_data !== 32'h0 || m_bytesel !== 4'h0 || ram_bytesel !== 4'h0) begin
      n_fail++; $display("FAIL abort_zero got ctl %b addr %h data %h bsel %h/%h exp all 0",
                         {busy, done, m_access, m_wr_en, ram_wr_en}, m_addr, m_data, m_bytesel, ram_bytesel);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || m_access || busy) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL abort_quiet got activity after reset exp none");
    end
    n_cmp++;
    if (wr_cnt - w0 != 1 || mem[20] !== 32'hF000_5000 || mem[21] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL abort_ram got writes %0d mem20 %h mem21 %h exp 1/f0005000/deadbeef",
                         wr_cnt - w0, mem[20], mem[21]);
    end
    test_fill(0, 3'd5, 32'h5000);
  endtask

  initial begin
    test_reset();
    test_fill(0, 3'd2, 32'h1000);
    test_writeback(0, 3'd1, 32'h2000);
    test_priority();
    test_ack_delay();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
